// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frogger_pkg
//  Purpose  : Shared geometry constants, traffic FSM state type and the lane
//             period helper used by the traffic engine.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package frogger_pkg;

  localparam int COORD_W    = 10;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int CAR_W      = 64;
  localparam int CAR_H      = 32;
  localparam int FROG_SIZE  = 32;
  localparam int LANE_Y0    = 96;
  localparam int LANE_PITCH = 64;

  localparam int LEVEL_W    = 4;
  localparam int LEVEL_MAX  = 15;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } traffic_state_t;

  // Frames per step for a lane: slower for higher lanes, faster with level,
  // never below one frame per step.
  function automatic int lane_period(input int base, input int lane, input int level);
    int raw;
    raw = base + lane - level;
    return (raw < 1) ? 1 : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_lane.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_lane
//  Purpose  : One car lane: frame counter, step with screen wrap, and a strict
//             rectangle overlap test of the (unwrapped) car against the frog.
//  Ports    : clk, reset (sync, active-low)
//             enable_i   - count one frame (RUN and frame_tick)
//             reload_i   - return car and counter to reset values
//             period_i   - frames per step for this lane (>= 1)
//             frog_x_i / frog_y_i - frog top-left corner
//             x_o / y_o  - car top-left corner
//             overlap_o  - combinational car/frog overlap
//  Revision : 1.0  initial release
// ============================================================================
module traffic_lane #(
  parameter int LANE_IDX   = 0,
  parameter bit MOVE_LEFT  = 1'b0,
  parameter int N_LANES    = 4,
  parameter int COORD_W    = frogger_pkg::COORD_W,
  parameter int SCREEN_W   = frogger_pkg::SCREEN_W,
  parameter int CAR_W      = frogger_pkg::CAR_W,
  parameter int CAR_H      = frogger_pkg::CAR_H,
  parameter int FROG_SIZE  = frogger_pkg::FROG_SIZE,
  parameter int LANE_Y0    = frogger_pkg::LANE_Y0,
  parameter int LANE_PITCH = frogger_pkg::LANE_PITCH,
  parameter int STEP_PX    = 8,
  parameter int PER_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               reload_i,
  input  logic [PER_W-1:0]   period_i,
  input  logic [COORD_W-1:0] frog_x_i,
  input  logic [COORD_W-1:0] frog_y_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               overlap_o
);

  // Sums are one bit wider than a coordinate so nothing wraps in compares.
  localparam int SUM_W = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_HOME = COORD_W'((LANE_IDX * SCREEN_W / N_LANES) % SCREEN_W);
  localparam logic [COORD_W-1:0] Y_LANE = COORD_W'(LANE_Y0 + LANE_IDX * LANE_PITCH);

  localparam logic [SUM_W-1:0] STEP_X  = SUM_W'(STEP_PX);
  localparam logic [SUM_W-1:0] SCR_X   = SUM_W'(SCREEN_W);
  localparam logic [SUM_W-1:0] CARW_X  = SUM_W'(CAR_W);
  localparam logic [SUM_W-1:0] CARH_X  = SUM_W'(CAR_H);
  localparam logic [SUM_W-1:0] FROG_X  = SUM_W'(FROG_SIZE);

  logic [COORD_W-1:0] x_q, x_d;
  logic [PER_W-1:0]   cnt_q, cnt_d;

  logic [SUM_W-1:0] x_ext, x_fwd, x_back;
  logic [SUM_W-1:0] y_ext, fx_ext, fy_ext;

  always_comb begin
    x_ext  = {1'b0, x_q};
    x_fwd  = x_ext + STEP_X;
    x_back = x_ext + SCR_X - STEP_X;
    cnt_d  = cnt_q;
    x_d    = x_q;
    if (reload_i) begin
      cnt_d = '0;
      x_d   = X_HOME;
    end else if (enable_i) begin
      // ">=" rather than "==" so a counter left above a freshly shortened
      // period (level change) steps at once instead of running round.
      if (cnt_q >= period_i - PER_W'(1)) begin
        cnt_d = '0;
        if (MOVE_LEFT) begin
          if (x_ext < STEP_X) x_d = COORD_W'(x_back);
          else                x_d = COORD_W'(x_ext - STEP_X);
        end else begin
          if (x_fwd >= SCR_X) x_d = COORD_W'(x_fwd - SCR_X);
          else                x_d = COORD_W'(x_fwd);
        end
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end
  end

  // Only the unwrapped rectangle [x, x+CAR_W) is tested.
  always_comb begin
    y_ext     = {1'b0, Y_LANE};
    fx_ext    = {1'b0, frog_x_i};
    fy_ext    = {1'b0, frog_y_i};
    overlap_o = (fx_ext < x_ext + CARW_X) && (x_ext < fx_ext + FROG_X) &&
                (fy_ext < y_ext + CARH_X) && (y_ext < fy_ext + FROG_X);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q   <= X_HOME;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign x_o = x_q;
  assign y_o = Y_LANE;

endmodule
`default_nettype wire

// File: rtl/traffic_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_lanes
//  Purpose  : Multi-lane traffic engine. Moves N_LANES cars (even lanes right,
//             odd lanes left) with per-lane periods, detects frog/car overlap,
//             and runs the RUN/HOLD hit-freeze machine that issues restart.
//  Ports    : clk, reset (sync, active-low)
//             frame_tick_i - one pulse per video frame
//             frog_x_i / frog_y_i - frog top-left corner
//             level_up_i   - one pulse per frog win
//             car_x_o / car_y_o - packed car corners, lane 0 in the LSBs
//             hit_o        - one-cycle pulse on collision
//             restart_o    - one-cycle pulse when the freeze ends
//             frozen_o     - high while in HOLD
//             level_o      - current difficulty
//  Config   : TRAFFIC_SPEEDUP_EN - when defined, level_up_i raises the level
//             (saturating at 15) and shortens lane periods; when undefined the
//             level is fixed at 0 and no level register exists.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_lanes #(
  parameter int N_LANES     = 4,
  parameter int COORD_W     = frogger_pkg::COORD_W,
  parameter int SCREEN_W    = frogger_pkg::SCREEN_W,
  parameter int CAR_W       = frogger_pkg::CAR_W,
  parameter int CAR_H       = frogger_pkg::CAR_H,
  parameter int FROG_SIZE   = frogger_pkg::FROG_SIZE,
  parameter int LANE_Y0     = frogger_pkg::LANE_Y0,
  parameter int LANE_PITCH  = frogger_pkg::LANE_PITCH,
  parameter int STEP_PX     = 8,
  parameter int BASE_PERIOD = 6,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick_i,
  input  logic [COORD_W-1:0]         frog_x_i,
  input  logic [COORD_W-1:0]         frog_y_i,
  input  logic                       level_up_i,
  output logic [N_LANES*COORD_W-1:0] car_x_o,
  output logic [N_LANES*COORD_W-1:0] car_y_o,
  output logic                       hit_o,
  output logic                       restart_o,
  output logic                       frozen_o,
  output logic [3:0]                 level_o
);

  import frogger_pkg::*;

  // Wide enough for the slowest lane period at level 0.
  localparam int PER_W  = $clog2(BASE_PERIOD + N_LANES);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  traffic_state_t      state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                ovl_q;
  logic                hit_q;
  logic                restart_q;
  logic                frozen_q;

  logic [N_LANES-1:0]  lane_ovl;
  logic                hit_take;
  logic                lane_en;
  logic                lane_reload;

  // The restart cycle still sees the overlap registered from the frozen
  // positions, so it is masked; the reloaded positions are judged next cycle.
  assign hit_take    = (state_q == RUN) && ovl_q && !restart_q;
  assign lane_en     = (state_q == RUN) && frame_tick_i;
  assign lane_reload = (state_q == HOLD) && frame_tick_i && (hold_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      hold_q    <= '0;
      ovl_q     <= 1'b0;
      hit_q     <= 1'b0;
      restart_q <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      ovl_q     <= |lane_ovl;
      hit_q     <= 1'b0;
      restart_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (hit_take) begin
            state_q  <= HOLD;
            hold_q   <= HOLD_W'(HOLD_FRAMES - 1);
            hit_q    <= 1'b1;
            frozen_q <= 1'b1;
          end
        end
        HOLD: begin
          if (frame_tick_i) begin
            if (hold_q == '0) begin
              state_q   <= RUN;
              restart_q <= 1'b1;
              frozen_q  <= 1'b0;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef TRAFFIC_SPEEDUP_EN
  logic [LEVEL_W-1:0] level_q;

  // A hit in the same cycle takes priority and swallows the level_up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= '0;
    end else if ((state_q == RUN) && level_up_i && !hit_take &&
                 (level_q != LEVEL_W'(LEVEL_MAX))) begin
      level_q <= level_q + LEVEL_W'(1);
    end
  end

  assign level_o = level_q;
`else
  logic unused_level_up;
  assign unused_level_up = level_up_i;
  assign level_o         = '0;
`endif

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [PER_W-1:0] period;

    assign period = PER_W'(lane_period(BASE_PERIOD, i, int'(level_o)));

    traffic_lane #(
      .LANE_IDX   (i),
      .MOVE_LEFT  ((i % 2) == 1),
      .N_LANES    (N_LANES),
      .COORD_W    (COORD_W),
      .SCREEN_W   (SCREEN_W),
      .CAR_W      (CAR_W),
      .CAR_H      (CAR_H),
      .FROG_SIZE  (FROG_SIZE),
      .LANE_Y0    (LANE_Y0),
      .LANE_PITCH (LANE_PITCH),
      .STEP_PX    (STEP_PX),
      .PER_W      (PER_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (lane_en),
      .reload_i  (lane_reload),
      .period_i  (period),
      .frog_x_i  (frog_x_i),
      .frog_y_i  (frog_y_i),
      .x_o       (car_x_o[i*COORD_W +: COORD_W]),
      .y_o       (car_y_o[i*COORD_W +: COORD_W]),
      .overlap_o (lane_ovl[i])
    );
  end

  assign hit_o     = hit_q;
  assign restart_o = restart_q;
  assign frozen_o  = frozen_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_lanes
//  Purpose  : Self-checking bench for traffic_lanes: directed scenarios plus
//             randomized frames, all compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_lanes;

  localparam int N     = 4;
  localparam int CW    = 10;
  localparam int SW    = 640;
  localparam int CARW  = 64;
  localparam int CARH  = 32;
  localparam int FS    = 32;
  localparam int Y0    = 96;
  localparam int PITCH = 64;
  localparam int STEP  = 8;
  localparam int BASE  = 6;
  localparam int HOLDF = 60;
  localparam int SAFE_Y = 400;
`ifdef TRAFFIC_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_tick = 1'b0;
  logic            level_up = 1'b0;
  logic [CW-1:0]   frog_x = '0;
  logic [CW-1:0]   frog_y = CW'(SAFE_Y);
  logic [N*CW-1:0] car_x, car_y;
  logic            hit, restart, frozen;
  logic [3:0]      level;

  always #5 clk = ~clk;

  traffic_lanes #(
    .N_LANES(N), .COORD_W(CW), .SCREEN_W(SW), .CAR_W(CARW), .CAR_H(CARH),
    .FROG_SIZE(FS), .LANE_Y0(Y0), .LANE_PITCH(PITCH), .STEP_PX(STEP),
    .BASE_PERIOD(BASE), .HOLD_FRAMES(HOLDF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick_i(frame_tick),
    .frog_x_i(frog_x), .frog_y_i(frog_y), .level_up_i(level_up),
    .car_x_o(car_x), .car_y_o(car_y), .hit_o(hit), .restart_o(restart),
    .frozen_o(frozen), .level_o(level)
  );

  // ---------------- reference model ----------------
  int m_x[N];
  int m_cnt[N];
  bit m_run, m_ovq, m_hit, m_restart, m_frozen;
  int m_hold, m_level;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int home_x(input int i);
    return (i * SW / N) % SW;
  endfunction

  function automatic int period(input int i, input int lvl);
    int p;
    p = BASE + i - lvl;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic bit overlaps(input int cx, input int cy, input int fx, input int fy);
    return (fx < cx + CARW) && (cx < fx + FS) && (fy < cy + CARH) && (cy < fy + FS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i]   = home_x(i);
      m_cnt[i] = 0;
    end
    m_run = 1; m_ovq = 0; m_hit = 0; m_restart = 0; m_frozen = 0;
    m_hold = 0; m_level = 0;
  endtask

  task automatic model_edge(input bit rst_n, input bit ft, input bit lu, input int fx, input int fy);
    bit ov;
    bit take;
    int lvl_old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ov = 0;
    for (int i = 0; i < N; i++) ov |= overlaps(m_x[i], Y0 + i * PITCH, fx, fy);
    take    = m_run && m_ovq && !m_restart;
    lvl_old = m_level;
    m_hit = 0;
    m_restart = 0;
    if (m_run) begin
      if (ft) begin
        for (int i = 0; i < N; i++) begin
          if (m_cnt[i] + 1 >= period(i, lvl_old)) begin
            m_cnt[i] = 0;
            if (i % 2 == 0) m_x[i] = (m_x[i] + STEP) % SW;
            else            m_x[i] = (m_x[i] - STEP + SW) % SW;
          end else begin
            m_cnt[i]++;
          end
        end
      end
      if (take) begin
        m_run = 0; m_hold = HOLDF - 1; m_hit = 1; m_frozen = 1;
      end else if (lu && SPEEDUP && m_level < 15) begin
        m_level++;
      end
    end else if (ft) begin
      if (m_hold == 0) begin
        for (int i = 0; i < N; i++) begin
          m_x[i] = home_x(i);
          m_cnt[i] = 0;
        end
        m_run = 1; m_restart = 1; m_frozen = 0;
      end else begin
        m_hold--;
      end
    end
    m_ovq = ov;
  endtask

  function automatic int dut_x(input int i);
    return int'(car_x[i*CW +: CW]);
  endfunction

  task automatic compare_all();
    check("hit", 32'(hit), 32'(m_hit));
    check("restart", 32'(restart), 32'(m_restart));
    check("frozen", 32'(frozen), 32'(m_frozen));
    check("level", 32'(level), m_level);
    for (int i = 0; i < N; i++) begin
      check($sformatf("car_x%0d", i), 32'(car_x[i*CW +: CW]), m_x[i]);
      check($sformatf("car_y%0d", i), 32'(car_y[i*CW +: CW]), Y0 + i * PITCH);
    end
  endtask

  task automatic cyc(input bit rst_n, input bit ft, input bit lu);
    reset = rst_n; frame_tick = ft; level_up = lu;
    @(posedge clk);
    model_edge(rst_n, ft, lu, int'(frog_x), int'(frog_y));
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen0, seen1;
    int guard, p0, p1, pexp;

    // Reset state
    frog_x = '0; frog_y = CW'(SAFE_Y);
    do_reset();
    for (int i = 0; i < N; i++) begin
      check("rst_x", 32'(car_x[i*CW +: CW]), i * 160);
      check("rst_y", 32'(car_y[i*CW +: CW]), 96 + i * 64);
    end
    check("rst_hit", 32'(hit), 0);
    check("rst_frozen", 32'(frozen), 0);
    check("rst_level", 32'(level), 0);

    // Six frame ticks at level 0
    cyc(1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 0);
    check("t6_x0", 32'(dut_x(0)), 8);
    check("t6_x1", 32'(dut_x(1)), 160);
    check("t6_x3", 32'(dut_x(3)), 480);
    check("t6_hit", 32'(hit), 0);
    cyc(1, 1, 0);
    check("t7_x1", 32'(dut_x(1)), 152);

    // Level-up pulses and lane 0 speed
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1, 0, 1);
    check("lvl_sat", 32'(level), SPEEDUP ? 15 : 0);
    cyc(1, 1, 0);
    check("lvl_p1_x0", 32'(dut_x(0)), SPEEDUP ? 8 : 0);

    // Screen wrap in both directions
    seen0 = 0; seen1 = 0; guard = 0;
    while (!(seen0 && seen1) && guard < 6000) begin
      p0 = m_x[0]; p1 = m_x[1];
      cyc(1, 1, 0);
      if (p0 == 632 && m_x[0] != 632) begin check("wrap_r", 32'(dut_x(0)), 0); seen0 = 1; end
      if (p1 == 0 && m_x[1] != 0) begin check("wrap_l", 32'(dut_x(1)), 632); seen1 = 1; end
      guard++;
    end
    if (!(seen0 && seen1)) check("wrap_timeout", 0, 1);
    check("wrap_nohit", 32'(hit), 0);

    // Frog on lane 0 at reset: hit two cycles after release, level_up dropped
    frog_x = '0; frog_y = CW'(96);
    do_reset();
    cyc(1, 0, 0);
    check("hit_early", 32'(hit), 0);
    cyc(1, 0, 1);
    check("hit_pulse", 32'(hit), 1);
    check("hit_frozen", 32'(frozen), 1);
    check("hit_lvl_drop", 32'(level), 0);
    cyc(1, 0, 1);
    check("hold_lvl_ign", 32'(level), 0);
    check("hit_once", 32'(hit), 0);
    for (int k = 0; k < HOLDF - 1; k++) cyc(1, 1, 0);
    check("hold_x0", 32'(dut_x(0)), 0);
    check("hold_x1", 32'(dut_x(1)), 160);
    check("hold_frozen", 32'(frozen), 1);
    cyc(1, 1, 0);
    check("restart", 32'(restart), 1);
    check("restart_frz", 32'(frozen), 0);
    for (int i = 0; i < N; i++) check("reload_x", 32'(dut_x(i)), i * 160);
    // Frog still on the car: restart cycle is ignored, reloaded position hits
    cyc(1, 0, 0);
    check("rs_ign_hit", 32'(hit), 0);
    cyc(1, 0, 0);
    check("rehit", 32'(hit), 1);

    // Reset for one cycle in HOLD
    frog_y = CW'(SAFE_Y);
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    check("rh_frozen", 32'(frozen), 0);
    check("rh_restart", 32'(restart), 0);
    check("rh_hit", 32'(hit), 0);
    check("rh_level", 32'(level), 0);

    // Three level_ups, then lane 0 step timing
    cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1);
    check("lu3_level", 32'(level), SPEEDUP ? 3 : 0);
    pexp = SPEEDUP ? 3 : 6;
    for (int k = 0; k < pexp - 1; k++) cyc(1, 1, 0);
    check("lu3_before", 32'(dut_x(0)), 0);
    cyc(1, 1, 0);
    check("lu3_step", 32'(dut_x(0)), 8);

    // Randomized frames against the model
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      if (k % 40 == 0) begin
        frog_x = CW'($urandom_range(0, SW - 1));
        if ($urandom_range(0, 2) == 0)
          frog_y = CW'(Y0 + PITCH * $urandom_range(0, N - 1) + $urandom_range(0, 40) - 20);
        else
          frog_y = CW'(SAFE_Y);
      end
      cyc($urandom_range(0, 399) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
